// File: rtl/game_flow_controller.sv
// Purpose: Frogger game sequencer. Owns game state, lives, score and lane directions, and drives freeze/active/frog-reset controls.
// Latency: every output is registered, so an input event shows up one i_Clk after the edge that samples it.
// Backpressure: none. Inputs are pulses or levels sampled every cycle; optional frog blink in HIT is enabled by macro FROG_BLINK_EN.
module game_flow_controller #(
  parameter int                  C_LIVES         = 3,
  parameter int                  C_RESPAWN_TICKS = 60,
  parameter int                  C_LEVELUP_TICKS = 30,
  parameter int                  C_MAX_SCORE     = 9,
  parameter int                  NUM_BITS        = 4,
  parameter logic [NUM_BITS-1:0] C_REVERSE_INI   = NUM_BITS'(4'b1010)
) (
  input  logic                i_Clk,
  input  logic                i_Rst,
  input  logic                i_Frame_Tick,
  input  logic                i_All_Switch,
  input  logic                i_Has_Collided,
  input  logic                i_Level_Up,
  output logic                o_Game_Active,
  output logic                o_Freeze,
  output logic                o_Frog_Reset,
  output logic [3:0]          o_Score,
  output logic [C_LIVES-1:0]  o_Lives,
  output logic [NUM_BITS-1:0] o_Reverse,
  output logic [2:0]          o_State,
  output logic                o_Game_Won,
  output logic                o_Frog_Visible
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RUNNING = 3'd1,
    HIT     = 3'd2,
    LEVEL   = 3'd3,
    OVER    = 3'd4
  } state_t;

  // The pause counter is shared by HIT and LEVEL; at least 3 bits so the blink
  // logic can look at its low bits to find every 8th frame tick.
  localparam int MAX_TICKS = (C_RESPAWN_TICKS > C_LEVELUP_TICKS) ? C_RESPAWN_TICKS : C_LEVELUP_TICKS;
  localparam int CNT_W     = ($clog2(MAX_TICKS) < 3) ? 3 : $clog2(MAX_TICKS);

  localparam logic [CNT_W-1:0]   RESPAWN_LAST = CNT_W'(C_RESPAWN_TICKS - 1);
  localparam logic [CNT_W-1:0]   LEVELUP_LAST = CNT_W'(C_LEVELUP_TICKS - 1);
  localparam logic [3:0]         MAX_SCORE    = 4'(C_MAX_SCORE);
  localparam logic [C_LIVES-1:0] LIVES_FULL   = '1;
  localparam logic [C_LIVES-1:0] LAST_LIFE    = C_LIVES'(1);

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     frame_cnt_q, frame_cnt_d;
  logic                 prev_collided_q;
  logic                 collision_evt;
  logic [CNT_W-1:0]     pause_last;
  logic [3:0]           score_inc;
  logic [C_LIVES-1:0]   lives_d;
  logic [3:0]           score_d;
  logic [NUM_BITS-1:0]  reverse_d;
  logic                 won_d;
  logic                 frog_reset_d;
  logic                 visible_d;

  // Next-state and next-output decode; everything holds unless a rule below changes it.
  always_comb begin
    state_d      = state_q;
    frame_cnt_d  = frame_cnt_q;
    lives_d      = o_Lives;
    score_d      = o_Score;
    reverse_d    = o_Reverse;
    won_d        = o_Game_Won;
    frog_reset_d = 1'b0;
    visible_d    = 1'b1;

    collision_evt = i_Has_Collided & ~prev_collided_q;
    pause_last    = (state_q == HIT) ? RESPAWN_LAST : LEVELUP_LAST;
    // Score saturates at 15 even though a sane C_MAX_SCORE ends the game first.
    score_inc     = (o_Score == 4'hF) ? 4'hF : o_Score + 4'd1;

    case (state_q)
      IDLE: begin
        if (i_All_Switch) begin
          state_d      = RUNNING;
          lives_d      = LIVES_FULL;
          score_d      = 4'd0;
          reverse_d    = C_REVERSE_INI;
          won_d        = 1'b0;
          frog_reset_d = 1'b1;
        end
      end
      RUNNING: begin
        // A collision on the same cycle as a level-up takes priority.
        if (collision_evt) begin
          lives_d = o_Lives >> 1;
          if (o_Lives == LAST_LIFE) begin
            state_d = OVER;
            won_d   = 1'b0;
          end else begin
            state_d     = HIT;
            frame_cnt_d = '0;
          end
        end else if (i_Level_Up) begin
          score_d = score_inc;
          if (score_inc == MAX_SCORE) begin
            state_d = OVER;
            won_d   = 1'b1;
          end else begin
            reverse_d   = {o_Reverse[NUM_BITS-2:0], o_Reverse[NUM_BITS-1]};
            state_d     = LEVEL;
            frame_cnt_d = '0;
          end
        end
      end
      HIT, LEVEL: begin
        if (i_Frame_Tick) begin
          if (frame_cnt_q == pause_last) begin
            state_d      = RUNNING;
            frog_reset_d = 1'b1;
          end else begin
            frame_cnt_d = frame_cnt_q + CNT_W'(1);
          end
        end
      end
      OVER: begin
        // Requires the switches to be released before a new game can start.
        if (!i_All_Switch) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

`ifdef FROG_BLINK_EN
    // Blink only while staying in HIT; entry and exit leave the frog visible.
    if (state_q == HIT && state_d == HIT) begin
      visible_d = o_Frog_Visible;
      if (i_Frame_Tick && frame_cnt_q[2:0] == 3'b111) begin
        visible_d = ~o_Frog_Visible;
      end
    end
`endif
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      state_q         <= IDLE;
      frame_cnt_q     <= '0;
      prev_collided_q <= 1'b0;
      o_Lives         <= LIVES_FULL;
      o_Score         <= 4'd0;
      o_Reverse       <= C_REVERSE_INI;
      o_Game_Won      <= 1'b0;
      o_Frog_Reset    <= 1'b0;
      o_Frog_Visible  <= 1'b1;
      o_Game_Active   <= 1'b0;
      o_Freeze        <= 1'b1;
      o_State         <= IDLE;
    end else begin
      state_q         <= state_d;
      frame_cnt_q     <= frame_cnt_d;
      prev_collided_q <= i_Has_Collided;
      o_Lives         <= lives_d;
      o_Score         <= score_d;
      o_Reverse       <= reverse_d;
      o_Game_Won      <= won_d;
      o_Frog_Reset    <= frog_reset_d;
      o_Frog_Visible  <= visible_d;
      o_Game_Active   <= (state_d == RUNNING);
      o_Freeze        <= (state_d != RUNNING);
      o_State         <= state_d;
    end
  end

endmodule
